// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and ROM front end: label pre-pass, execute pass, branch/stall/halt handling (option: FETCH_LABEL_CHECK_EN)
module instruction_fetch #(
  parameter int                  PC_W       = 8,
  parameter int                  INSTR_W    = 8,
  parameter int                  NUM_LABELS = 16,
  parameter logic [INSTR_W-1:0]  BUBBLE     = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    program_counter,
  output logic [INSTR_W-1:0] instruction,
  output logic               labelPassFlagOut,
  input  logic               inputPCResetFlag,
  input  logic               labelFlag,
  input  logic [PC_W-1:0]    labelValue,
  input  logic [3:0]         label_idx,
  input  logic               branchFlag,
  input  logic               branch_taken,
  input  logic [3:0]         branch_idx,
  input  logic               haltFlag,
  input  logic               stall_flag,
  output logic               done
`ifdef FETCH_LABEL_CHECK_EN
  , output logic             label_err
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LABEL_PASS = 2'd1,
    EXEC       = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t               state, state_next;
  logic [PC_W-1:0]      pc, pc_next;
  logic [PC_W-1:0]      pc_out_next;
  logic [INSTR_W-1:0]   instr_next;
  logic                 tbl_we;
  logic [PC_W-1:0]      label_table [NUM_LABELS];

`ifdef FETCH_LABEL_CHECK_EN
  logic [NUM_LABELS-1:0] label_valid;
  logic                  valid_clr;
  logic                  err_set;
`endif

  assign imem_addr        = pc;
  assign labelPassFlagOut = (state == LABEL_PASS);
  assign done             = (state == HALTED);

  // Next-state and fetch datapath selection; the decoder flags refer to the previous issue slot
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    pc_out_next = program_counter;
    instr_next  = instruction;
    tbl_we      = 1'b0;
`ifdef FETCH_LABEL_CHECK_EN
    valid_clr   = 1'b0;
    err_set     = 1'b0;
`endif
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_next = LABEL_PASS;
          pc_next    = '0;
`ifdef FETCH_LABEL_CHECK_EN
          valid_clr  = 1'b1;
`endif
        end
      end
      LABEL_PASS: begin
        tbl_we = labelFlag;
        if (inputPCResetFlag) begin
          state_next = EXEC;
          pc_next    = '0;
          instr_next = BUBBLE;
        end else begin
          instr_next  = imem_data;
          pc_out_next = pc;
          pc_next     = pc + PC_ONE;
        end
      end
      EXEC: begin
        if (haltFlag) begin
          state_next = HALTED;
          instr_next = BUBBLE;
        end else if (branchFlag && branch_taken) begin
          instr_next = BUBBLE;
`ifdef FETCH_LABEL_CHECK_EN
          if (!label_valid[branch_idx]) begin
            state_next = HALTED;
            err_set    = 1'b1;
          end else begin
            pc_next = label_table[branch_idx];
          end
`else
          pc_next = label_table[branch_idx];
`endif
        end else if (stall_flag) begin
          instr_next = BUBBLE;
        end else begin
          instr_next  = imem_data;
          pc_out_next = pc;
          pc_next     = pc + PC_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, PC and decoder-facing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= '0;
      program_counter <= '0;
      instruction     <= BUBBLE;
    end else begin
      state           <= state_next;
      pc              <= pc_next;
      program_counter <= pc_out_next;
      instruction     <= instr_next;
    end
  end

  // Label table filled by stl during the label pass; wiped on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LABELS; i++) label_table[i] <= '0;
    end else if (tbl_we) begin
      label_table[label_idx] <= labelValue;
    end
  end

`ifdef FETCH_LABEL_CHECK_EN
  // Per-slot valid bits and the sticky error for branches to unwritten labels
  always_ff @(posedge clk) begin
    if (reset) begin
      label_valid <= '0;
      label_err   <= 1'b0;
    end else begin
      if (valid_clr)   label_valid <= '0;
      else if (tbl_we) label_valid[label_idx] <= 1'b1;
      if (err_set)     label_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] imem_addr, imem_data, program_counter, instruction;
  logic       labelPassFlagOut, inputPCResetFlag, labelFlag;
  logic [7:0] labelValue;
  logic [3:0] label_idx, branch_idx;
  logic       branchFlag, branch_taken, haltFlag, stall_flag, done;
`ifdef FETCH_LABEL_CHECK_EN
  logic       label_err;
`endif

  logic [7:0] rom [256];

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .program_counter(program_counter), .instruction(instruction),
    .labelPassFlagOut(labelPassFlagOut), .inputPCResetFlag(inputPCResetFlag),
    .labelFlag(labelFlag), .labelValue(labelValue), .label_idx(label_idx),
    .branchFlag(branchFlag), .branch_taken(branch_taken), .branch_idx(branch_idx),
    .haltFlag(haltFlag), .stall_flag(stall_flag), .done(done)
`ifdef FETCH_LABEL_CHECK_EN
    , .label_err(label_err)
`endif
  );

  function automatic logic [7:0] romv(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    inputPCResetFlag = 0; labelFlag = 0; labelValue = 0; label_idx = 0;
    branchFlag = 0; branch_taken = 0; branch_idx = 0; haltFlag = 0; stall_flag = 0;
  endtask

  task automatic push_exp(input logic [7:0] i, input logic [7:0] p, input logic [7:0] a);
    exp_t x;
    x.instr = i; x.pc = p; x.addr = a;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    reset = 1; start = 0; clear_in();
    repeat (3) tick();
    total++;
    if (imem_addr !== 8'h00 || instruction !== 8'hF0 || program_counter !== 8'h00 ||
        labelPassFlagOut !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state addr=%h instr=%h pc=%h lp=%b done=%b want 00 f0 00 0 0",
               imem_addr, instruction, program_counter, labelPassFlagOut, done);
    end
`ifdef FETCH_LABEL_CHECK_EN
    total++;
    if (label_err !== 1'b0) begin bad++; $display("FAIL reset_label_err got=%b want=0", label_err); end
`endif
    reset = 0;
    tick();
    total++;
    if (imem_addr !== 8'h00 || instruction !== 8'hF0 || labelPassFlagOut !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold addr=%h instr=%h lp=%b want 00 f0 0", imem_addr, instruction, labelPassFlagOut);
    end
  endtask

  task automatic test_label_pass;
    start = 1; tick(); start = 0;
    total++;
    if (labelPassFlagOut !== 1'b1 || imem_addr !== 8'h00 || done !== 1'b0) begin
      bad++;
      $display("FAIL lp_enter lp=%b addr=%h done=%b want 1 00 0", labelPassFlagOut, imem_addr, done);
    end
    push_exp(romv(8'd0), 8'd0, 8'd1); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL lp_fetch0 got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    labelFlag = 1; label_idx = 3; labelValue = 8'h00;
    push_exp(romv(8'd1), 8'd1, 8'd2); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL lp_stl got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    labelValue = 8'h05; branchFlag = 1; branch_taken = 1; branch_idx = 3; haltFlag = 1; stall_flag = 1;
    push_exp(romv(8'd2), 8'd2, 8'd3); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL lp_ignore_flags got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in(); labelFlag = 1; label_idx = 4; labelValue = 8'h08; inputPCResetFlag = 1;
    push_exp(8'hF0, 8'd2, 8'd0); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL lp_end got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in();
    total++;
    if (labelPassFlagOut !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL lp_exit lp=%b done=%b want 0 0", labelPassFlagOut, done);
    end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 2; k++) begin
      push_exp(romv(8'(k)), 8'(k), 8'(k + 1)); tick(); e = sb.pop_front(); total++;
      if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
        bad++; $display("FAIL ex_seq%0d got=%h/%h/%h want=%h/%h/%h", k, instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
      end
    end
    branchFlag = 1; branch_taken = 0; branch_idx = 3;
    push_exp(romv(8'd2), 8'd2, 8'd3); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL br_not_taken got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    branch_taken = 1;
    push_exp(8'hF0, 8'd2, 8'd5); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL br_taken_slot3 got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in();
    push_exp(romv(8'd5), 8'd5, 8'd6); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL br_target_fetch got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    branchFlag = 1; branch_taken = 1; branch_idx = 4; stall_flag = 1;
    push_exp(8'hF0, 8'd5, 8'd8); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL br_over_stall got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in();
  endtask

  task automatic test_stall;
    stall_flag = 1;
    push_exp(8'hF0, 8'd5, 8'd8); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL stall_bubble got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    stall_flag = 0;
    for (int k = 8; k < 10; k++) begin
      push_exp(romv(8'(k)), 8'(k), 8'(k + 1)); tick(); e = sb.pop_front(); total++;
      if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
        bad++; $display("FAIL stall_resume%0d got=%h/%h/%h want=%h/%h/%h", k, instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
      end
    end
  endtask

  task automatic test_halt;
    haltFlag = 1; branchFlag = 1; branch_taken = 1; branch_idx = 3;
    push_exp(8'hF0, 8'd9, 8'd10); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr, done} !== {e.instr, e.pc, e.addr, 1'b1}) begin
      bad++; $display("FAIL halt_over_branch got=%h/%h/%h done=%b want=%h/%h/%h done=1", instruction, program_counter, imem_addr, done, e.instr, e.pc, e.addr);
    end
    clear_in(); labelFlag = 1; inputPCResetFlag = 1; stall_flag = 1;
    for (int k = 0; k < 3; k++) begin
      push_exp(8'hF0, 8'd9, 8'd10); tick(); e = sb.pop_front(); total++;
      if ({instruction, program_counter, imem_addr, done} !== {e.instr, e.pc, e.addr, 1'b1}) begin
        bad++; $display("FAIL halted_hold%0d got=%h/%h/%h done=%b want=%h/%h/%h done=1", k, instruction, program_counter, imem_addr, done, e.instr, e.pc, e.addr);
      end
    end
    clear_in();
  endtask

  task automatic test_restart_wrap;
    start = 1; tick(); start = 0;
    total++;
    if (labelPassFlagOut !== 1'b1 || done !== 1'b0 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL restart lp=%b done=%b addr=%h want 1 0 00", labelPassFlagOut, done, imem_addr);
    end
    for (int k = 0; k < 258; k++) begin
      push_exp(romv(8'(k)), 8'(k), 8'(k + 1));
      tick(); e = sb.pop_front(); total++;
      if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
        bad++; $display("FAIL wrap_step%0d got=%h/%h/%h want=%h/%h/%h", k, instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
      end
    end
    inputPCResetFlag = 1;
    push_exp(8'hF0, 8'd1, 8'd0); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr, labelPassFlagOut} !== {e.instr, e.pc, e.addr, 1'b0}) begin
      bad++; $display("FAIL wrap_pass_end got=%h/%h/%h lp=%b want=%h/%h/%h lp=0", instruction, program_counter, imem_addr, labelPassFlagOut, e.instr, e.pc, e.addr);
    end
    clear_in();
  endtask

  task automatic test_reset_mid_exec;
    for (int k = 0; k < 2; k++) begin
      push_exp(romv(8'(k)), 8'(k), 8'(k + 1)); tick(); e = sb.pop_front(); total++;
      if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
        bad++; $display("FAIL mid_exec%0d got=%h/%h/%h want=%h/%h/%h", k, instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
      end
    end
    reset = 1; haltFlag = 1;
    repeat (3) tick();
    reset = 0; clear_in();
    total++;
    if (imem_addr !== 8'h00 || instruction !== 8'hF0 || program_counter !== 8'h00 ||
        labelPassFlagOut !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_exec addr=%h instr=%h pc=%h lp=%b done=%b want 00 f0 00 0 0",
               imem_addr, instruction, program_counter, labelPassFlagOut, done);
    end
    tick();
    total++;
    if (imem_addr !== 8'h00 || instruction !== 8'hF0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_to_idle addr=%h instr=%h done=%b want 00 f0 0", imem_addr, instruction, done);
    end
  endtask

  task automatic test_unwritten_slot;
    start = 1; tick(); start = 0;
    push_exp(romv(8'd0), 8'd0, 8'd1); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL us_lp0 got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    inputPCResetFlag = 1;
    push_exp(8'hF0, 8'd0, 8'd0); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL us_lp_end got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in();
    push_exp(romv(8'd0), 8'd0, 8'd1); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL us_ex0 got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    branchFlag = 1; branch_taken = 1; branch_idx = 7;
`ifdef FETCH_LABEL_CHECK_EN
    push_exp(8'hF0, 8'd0, 8'd1); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr, done, label_err} !== {e.instr, e.pc, e.addr, 1'b1, 1'b1}) begin
      bad++; $display("FAIL us_label_err got=%h/%h/%h done=%b err=%b want=%h/%h/%h done=1 err=1", instruction, program_counter, imem_addr, done, label_err, e.instr, e.pc, e.addr);
    end
    clear_in();
    tick();
    total++;
    if (label_err !== 1'b1 || done !== 1'b1 || imem_addr !== 8'd1) begin
      bad++; $display("FAIL us_err_sticky err=%b done=%b addr=%h want 1 1 01", label_err, done, imem_addr);
    end
`else
    push_exp(8'hF0, 8'd0, 8'd0); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr, done} !== {e.instr, e.pc, e.addr, 1'b0}) begin
      bad++; $display("FAIL us_slot7_zero got=%h/%h/%h done=%b want=%h/%h/%h done=0", instruction, program_counter, imem_addr, done, e.instr, e.pc, e.addr);
    end
    clear_in();
    push_exp(romv(8'd0), 8'd0, 8'd1); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL us_after_jump got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    branchFlag = 1; branch_taken = 1; branch_idx = 3;
    push_exp(8'hF0, 8'd0, 8'd0); tick(); e = sb.pop_front(); total++;
    if ({instruction, program_counter, imem_addr} !== {e.instr, e.pc, e.addr}) begin
      bad++; $display("FAIL us_table_not_retained got=%h/%h/%h want=%h/%h/%h", instruction, program_counter, imem_addr, e.instr, e.pc, e.addr);
    end
    clear_in();
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = romv(8'(i));
    reset = 1; start = 0; clear_in();
    test_reset();
    test_label_pass();
    test_branch();
    test_stall();
    test_halt();
    test_restart_wrap();
    test_reset_mid_exec();
    test_unwritten_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
